// File: rtl/hdd_sd_pkg.sv
// Shared types for the IIgs hard-drive to hps_io sector-request controller.
package hdd_sd_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER} hdd_state_t;

    typedef struct packed {
        logic        valid;
        logic        wr;
        logic [31:0] lba;
    } hdd_req_t;

    localparam int unsigned REQ_LBA_W = 32;

    function automatic hdd_req_t mk_req(logic valid, logic wr, logic [31:0] lba);
        hdd_req_t r;
        r.valid = valid;
        r.wr    = wr;
        r.lba   = lba;
        return r;
    endfunction

endpackage

// File: rtl/hdd_req_queue.sv
// Active request slot plus a one-deep pending slot; pending wins over a new pulse at launch.
module hdd_req_queue
    import hdd_sd_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rd_i,
    input  logic                 wr_i,
    input  logic [REQ_LBA_W-1:0] lba_i,
    input  logic                 idle_i,
    input  logic                 done_i,
    input  logic                 flush_i,
    output logic                 launch_o,
    output logic                 ovf_o,
    output logic                 active_wr_o,
    output logic [REQ_LBA_W-1:0] active_lba_o
);

    hdd_req_t act_q, act_d;
    hdd_req_t pend_q, pend_d;
    hdd_req_t first_req, second_req;

    always_comb begin
        // A simultaneous read and write: the read is handled first, the write queues behind it.
        first_req  = mk_req(rd_i | wr_i, ~rd_i, lba_i);
        second_req = mk_req(rd_i & wr_i, 1'b1, lba_i);
        act_d      = act_q;
        pend_d     = pend_q;
        launch_o   = 1'b0;
        ovf_o      = 1'b0;

        if (done_i) begin
            act_d.valid = 1'b0;
        end

        if (idle_i && (pend_q.valid || first_req.valid)) begin
            launch_o = 1'b1;
            if (pend_q.valid) begin
                act_d        = pend_q;
                pend_d.valid = 1'b0;
            end else begin
                act_d           = first_req;
                first_req.valid = 1'b0;
            end
        end

        if (first_req.valid) begin
            ovf_o  = ovf_o | pend_d.valid;
            pend_d = first_req;
        end
        if (second_req.valid) begin
            ovf_o  = ovf_o | pend_d.valid;
            pend_d = second_req;
        end

        if (flush_i) begin
            pend_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            act_q  <= '0;
            pend_q <= '0;
        end else begin
            act_q  <= act_d;
            pend_q <= pend_d;
        end
    end

    assign active_wr_o  = act_q.wr;
    assign active_lba_o = act_q.lba;

endmodule

// File: rtl/hdd_sd_ctrl.sv
// Sector-request controller: turns hard-drive request pulses into held sd_rd/sd_wr levels,
// stalls the CPU for the transfer, tracks mount state and aborts hung transfers.
module hdd_sd_ctrl
    import hdd_sd_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd16777215,
    parameter int unsigned LBA_W          = 32
) (
    input  logic             clk_sys_i,
    input  logic             reset_n_i,
    input  logic             hdd_read_i,
    input  logic             hdd_write_i,
    input  logic [LBA_W-1:0] hdd_lba_i,
    input  logic             img_mounted_i,
    input  logic [63:0]      img_size_i,
    input  logic             img_readonly_i,
    output logic [LBA_W-1:0] sd_lba_o,
    output logic             sd_rd_o,
    output logic             sd_wr_o,
    input  logic             sd_ack_i,
    output logic             cpu_wait_o,
    output logic             hdd_mounted_o,
    output logic             hdd_protect_o,
    output logic             hdd_error_o,
    output logic             busy_o
);

    localparam int unsigned CntW =
        (TIMEOUT_CYCLES == 24'd0) ? 1 : $clog2(32'(TIMEOUT_CYCLES) + 32'd1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

    hdd_state_t            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  ack_q;
    logic                  mounted_q, protect_q;
    logic                  error_q, error_d;
    logic                  acc_rd, acc_wr, reject, unmount, active;
    logic                  launch, ovf, done, abort;
    logic                  act_wr;
    logic [REQ_LBA_W-1:0]  act_lba;

    // Mount/protect are judged on the state held before this cycle's mount strobe.
    assign acc_rd  = hdd_read_i & mounted_q;
    assign acc_wr  = hdd_write_i & mounted_q & ~protect_q;
    assign reject  = (hdd_read_i & ~mounted_q) | (hdd_write_i & ~(mounted_q & ~protect_q));
    assign unmount = img_mounted_i & (img_size_i == 64'd0);
    assign active  = (state_q != ST_IDLE);

    hdd_req_queue u_queue (
        .clk_i        (clk_sys_i),
        .rst_ni       (reset_n_i),
        .rd_i         (acc_rd),
        .wr_i         (acc_wr),
        .lba_i        (REQ_LBA_W'(hdd_lba_i)),
        .idle_i       (state_q == ST_IDLE),
        .done_i       (done),
        .flush_i      (unmount & active),
        .launch_o     (launch),
        .ovf_o        (ovf),
        .active_wr_o  (act_wr),
        .active_lba_o (act_lba)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        abort   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = ST_REQ;
                    cnt_d   = '0;
                end
            end
            ST_REQ: begin
                if (sd_ack_i && !ack_q) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (!sd_ack_i && ack_q) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Watchdog saturates at the compare point; abort overrides any ack-driven move.
        if (active) begin
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (((TIMEOUT_CYCLES != 24'd0) && (cnt_d == CntMax)) || unmount) begin
                state_d = ST_IDLE;
                done    = 1'b1;
                abort   = 1'b1;
            end
        end

        error_d = reject | ovf | abort;
    end

    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            mounted_q <= 1'b0;
            protect_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= sd_ack_i;
            error_q <= error_d;
            if (img_mounted_i) begin
                mounted_q <= (img_size_i != 64'd0);
                protect_q <= img_readonly_i;
            end
        end
    end

    assign sd_lba_o      = LBA_W'(act_lba);
    assign sd_rd_o       = (state_q == ST_REQ) & ~act_wr;
    assign sd_wr_o       = (state_q == ST_REQ) & act_wr;
    assign cpu_wait_o    = active;
    assign busy_o        = active;
    assign hdd_mounted_o = mounted_q;
    assign hdd_protect_o = protect_q;
    assign hdd_error_o   = error_q;

endmodule

// File: tb/tb_hdd_sd_ctrl.sv
// Bench for hdd_sd_ctrl: directed table, corner-case sequences, then random traffic vs a model.
module tb_hdd_sd_ctrl;

    localparam int T = 100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        hdd_read, hdd_write;
    logic [31:0] hdd_lba;
    logic        img_mounted;
    logic [63:0] img_size;
    logic        img_readonly;
    logic        sd_ack;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, cpu_wait, hdd_mounted, hdd_protect, hdd_error, busy;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    hdd_sd_ctrl #(
        .TIMEOUT_CYCLES (24'd100),
        .LBA_W          (32)
    ) dut (
        .clk_sys_i      (clk),
        .reset_n_i      (reset_n),
        .hdd_read_i     (hdd_read),
        .hdd_write_i    (hdd_write),
        .hdd_lba_i      (hdd_lba),
        .img_mounted_i  (img_mounted),
        .img_size_i     (img_size),
        .img_readonly_i (img_readonly),
        .sd_lba_o       (sd_lba),
        .sd_rd_o        (sd_rd),
        .sd_wr_o        (sd_wr),
        .sd_ack_i       (sd_ack),
        .cpu_wait_o     (cpu_wait),
        .hdd_mounted_o  (hdd_mounted),
        .hdd_protect_o  (hdd_protect),
        .hdd_error_o    (hdd_error),
        .busy_o         (busy)
    );

    // Reference model: a request in service, its ack progress, and a queue of at most one.
    typedef struct {
        logic        wr;
        logic [31:0] lba;
    } mreq_t;

    mreq_t       pend[$];
    bit          m_busy, m_acked, m_wr, m_mnt, m_pro, m_err, m_prev_ack;
    logic [31:0] m_lba;
    int          m_age;

    function automatic void model_reset();
        pend.delete();
        m_busy = 0; m_acked = 0; m_wr = 0; m_mnt = 0; m_pro = 0; m_err = 0;
        m_prev_ack = 0; m_lba = '0; m_age = 0;
    endfunction

    function automatic void model_step();
        mreq_t news[$];
        mreq_t r;
        bit    err;
        err = 0;
        if (hdd_read) begin
            if (m_mnt) begin r.wr = 0; r.lba = hdd_lba; news.push_back(r); end
            else err = 1;
        end
        if (hdd_write) begin
            if (m_mnt && !m_pro) begin r.wr = 1; r.lba = hdd_lba; news.push_back(r); end
            else err = 1;
        end
        if (!m_busy) begin
            if (pend.size() > 0 || news.size() > 0) begin
                if (pend.size() > 0) r = pend.pop_front();
                else r = news.pop_front();
                m_busy = 1; m_acked = 0; m_age = 0; m_wr = r.wr; m_lba = r.lba;
            end
        end else begin
            m_age++;
            if (!m_acked && sd_ack && !m_prev_ack) m_acked = 1;
            else if (m_acked && !sd_ack && m_prev_ack) m_busy = 0;
            if (m_age == T || (img_mounted && img_size == 64'd0)) begin
                m_busy = 0;
                err = 1;
                if (img_mounted && img_size == 64'd0) pend.delete();
            end
        end
        foreach (news[i]) begin
            if (pend.size() > 0) begin err = 1; pend.delete(); end
            pend.push_back(news[i]);
        end
        if (img_mounted) begin m_mnt = (img_size != 64'd0); m_pro = img_readonly; end
        m_prev_ack = sd_ack;
        m_err = err;
    endfunction

    function automatic logic [38:0] got_vec();
        return {sd_rd, sd_wr, cpu_wait, hdd_mounted, hdd_protect, hdd_error, busy, sd_lba};
    endfunction

    function automatic logic [38:0] exp_vec();
        return {m_busy & !m_acked & !m_wr, m_busy & !m_acked & m_wr, m_busy, m_mnt, m_pro,
                m_err, m_busy, m_lba};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, want);
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge, pulses cleared.
    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        check("model", 64'(got_vec()), 64'(exp_vec()));
        hdd_read    = 1'b0;
        hdd_write   = 1'b0;
        img_mounted = 1'b0;
    endtask

    typedef struct {
        logic        rd, wr;
        logic [31:0] lba;
        logic        ack, mnt;
        logic [63:0] size;
        logic        ro;
        logic [3:0]  e_ctl;  // {sd_rd, sd_wr, cpu_wait, hdd_error}
        logic [31:0] e_lba;
    } vec_t;

    function automatic vec_t row(bit rd, bit wr, int lba, bit ack, bit mnt, int size, bit ro,
                                 logic [3:0] e, int elba);
        vec_t v;
        v.rd = rd; v.wr = wr; v.lba = 32'(lba); v.ack = ack; v.mnt = mnt;
        v.size = 64'(size); v.ro = ro; v.e_ctl = e; v.e_lba = 32'(elba);
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[16];
        int   hi;
        int   stall;

        tbl[0]  = row(0, 0, 0,  0, 1, 1024, 0, 4'b0000, 0);
        tbl[1]  = row(1, 0, 5,  0, 0, 0,    0, 4'b1010, 5);
        tbl[2]  = row(0, 0, 0,  0, 0, 0,    0, 4'b1010, 5);
        tbl[3]  = row(0, 0, 0,  0, 0, 0,    0, 4'b1010, 5);
        tbl[4]  = row(0, 0, 0,  1, 0, 0,    0, 4'b0010, 5);
        tbl[5]  = row(0, 0, 0,  1, 0, 0,    0, 4'b0010, 5);
        tbl[6]  = row(0, 0, 0,  0, 0, 0,    0, 4'b0000, 5);
        tbl[7]  = row(0, 0, 0,  0, 1, 0,    0, 4'b0000, 5);
        tbl[8]  = row(1, 0, 9,  0, 0, 0,    0, 4'b0001, 5);
        tbl[9]  = row(0, 0, 0,  0, 0, 0,    0, 4'b0000, 5);
        tbl[10] = row(0, 0, 0,  0, 1, 2048, 1, 4'b0000, 5);
        tbl[11] = row(0, 1, 11, 0, 0, 0,    0, 4'b0001, 5);
        tbl[12] = row(1, 0, 12, 0, 0, 0,    0, 4'b1010, 12);
        tbl[13] = row(0, 0, 0,  1, 0, 0,    0, 4'b0010, 12);
        tbl[14] = row(0, 0, 0,  0, 0, 0,    0, 4'b0000, 12);
        tbl[15] = row(0, 0, 0,  0, 1, 2048, 0, 4'b0000, 12);

        reset_n = 1'b0; hdd_read = 0; hdd_write = 0; hdd_lba = '0;
        img_mounted = 0; img_size = '0; img_readonly = 0; sd_ack = 0;
        model_reset();
        #1;
        check("reset outputs", 64'(got_vec()), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            hdd_read = tbl[i].rd; hdd_write = tbl[i].wr; hdd_lba = tbl[i].lba;
            sd_ack = tbl[i].ack; img_mounted = tbl[i].mnt; img_size = tbl[i].size;
            img_readonly = tbl[i].ro;
            tick();
            check($sformatf("table row %0d", i), {28'd0, sd_rd, sd_wr, cpu_wait, hdd_error, sd_lba},
                  {28'd0, tbl[i].e_ctl, tbl[i].e_lba});
        end

        // Simultaneous read and write: read first, one idle gap, then the write.
        hdd_read = 1; hdd_write = 1; hdd_lba = 32'd7;
        tick();
        check("rw read first", {sd_rd, sd_wr, sd_lba}, {1'b1, 1'b0, 32'd7});
        sd_ack = 1; tick(); tick();
        sd_ack = 0; tick();
        check("b2b wait gap", cpu_wait, 0);
        tick();
        check("b2b write launch", {sd_wr, sd_rd, cpu_wait, sd_lba}, {3'b101, 32'd7});
        sd_ack = 1; tick();
        sd_ack = 0; tick();
        check("b2b done", busy, 0);

        // Watchdog: no ack ever arrives.
        hdd_read = 1; hdd_lba = 32'd20;
        tick();
        hi = 0;
        while (sd_rd === 1'b1 && hi < 200) begin
            hi++;
            tick();
        end
        check("timeout length", 64'(hi), 64'(T));
        check("timeout abort", {sd_rd, cpu_wait, hdd_error}, 3'b001);
        tick();
        check("timeout err pulse", hdd_error, 0);

        // Two pulses while transferring: last wins, one error.
        hdd_read = 1; hdd_lba = 32'd1; tick();
        sd_ack = 1; tick();
        hdd_read = 1; hdd_lba = 32'd3; tick();
        check("first queued no err", hdd_error, 0);
        hdd_read = 1; hdd_lba = 32'd9; tick();
        check("overwrite err", hdd_error, 1);
        tick();
        check("overwrite err pulse", hdd_error, 0);
        sd_ack = 0; tick();
        check("pend gap", cpu_wait, 0);
        tick();
        check("pend last wins", {sd_rd, sd_lba}, {1'b1, 32'd9});
        sd_ack = 1; tick();
        sd_ack = 0; tick();

        // Asynchronous reset in XFER with a request pending.
        hdd_read = 1; hdd_lba = 32'd33; tick();
        sd_ack = 1; tick();
        hdd_write = 1; hdd_lba = 32'd44; tick();
        reset_n = 1'b0;
        #1;
        check("async reset", {sd_rd, sd_wr, cpu_wait, busy, hdd_error, hdd_mounted, sd_lba},
              {6'd0, 32'd0});
        sd_ack = 0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        img_mounted = 1; img_size = 64'd4096; img_readonly = 0;
        tick(); tick(); tick();
        check("no pending after reset", {busy, hdd_mounted}, 2'b01);

        // Random traffic, with occasional remounts and long ack stalls.
        stall = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                img_mounted  = 1;
                img_size     = ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(1, 99999));
                img_readonly = 1'($urandom_range(0, 1));
            end else begin
                hdd_read  = ($urandom_range(0, 9) == 0);
                hdd_write = ($urandom_range(0, 11) == 0);
                hdd_lba   = $urandom;
            end
            if (stall > 0) stall--;
            else if ($urandom_range(0, 299) == 0) stall = 150;
            else if ($urandom_range(0, 3) == 0) sd_ack = ~sd_ack;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
